// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter sharing one line memory between the data  |
// | port (m0, read/write) and the refill port (m1, read-only). Rev 1.0         |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int              WAIT_CYCLES = 2,
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              LINE_W      = 256,
  parameter int              SEL_W       = 2,
  parameter logic [SEL_W-1:0] BYTE_SEL   = 'd1,
  parameter logic [SEL_W-1:0] HALF_SEL   = 'd2,
  parameter logic [SEL_W-1:0] WORD_SEL   = 'd3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_ack,
  output logic [LINE_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ack,
  output logic [LINE_W-1:0] m1_rdata,
  output logic              busy,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [LINE_W-1:0] mem_rd_data,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [SEL_W-1:0]  mem_wr_sel,
  output logic              mem_we
);

  localparam int OFS_W = $clog2(LINE_W / 8);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              owner;       // 0 = m0, 1 = m1
  logic              last_grant;  // 1 = m1 was granted last
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic [3:0]        cnt;

  logic              pick_m1;
  logic              sel_ok;
  logic [ADDR_W-1:0] line_addr;

  assign pick_m1   = m1_req && (!m0_req || !last_grant);
  assign sel_ok    = (sel_q == BYTE_SEL) || (sel_q == HALF_SEL) || (sel_q == WORD_SEL);
  assign line_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  // Reads present the line-aligned address on both ports so the memory sees one address.
  assign mem_rd_addr = we_q ? addr_q : line_addr;
  assign mem_wr_addr = mem_rd_addr;
  assign mem_wr_data = wdata_q;
  assign mem_wr_sel  = sel_q;

  assign busy   = (state != IDLE);
  assign mem_ce = (state == WAIT) && !we_q;
  assign mem_we = (state == DONE) && we_q && sel_ok;
  assign m0_ack = (state == DONE) && !owner;
  assign m1_ack = (state == DONE) && owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      cnt        <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= WAIT;
            owner      <= pick_m1;
            last_grant <= pick_m1;
            cnt        <= 4'(WAIT_CYCLES - 1);
            if (pick_m1) begin
              we_q   <= 1'b0;
              addr_q <= m1_addr;
            end else begin
              we_q    <= m0_we;
              addr_q  <= m0_addr;
              wdata_q <= m0_wdata;
              sel_q   <= m0_sel;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!we_q) begin
              if (owner) m1_rdata <= mem_rd_data;
              else       m0_rdata <= mem_rd_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for mem_arbiter: random and directed accesses against a byte-array
// reference memory, with a queue-based scoreboard checking every ack.
module tb_mem_arbiter;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m0_req, m0_we, m1_req;
  logic [31:0]  m0_addr, m0_wdata, m1_addr;
  logic [1:0]   m0_sel;
  logic         m0_ack, m1_ack, busy, mem_ce, mem_we;
  logic [255:0] m0_rdata, m1_rdata, mem_rd_data;
  logic [31:0]  mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [1:0]   mem_wr_sel;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .busy(busy), .mem_ce(mem_ce), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_sel(mem_wr_sel),
    .mem_we(mem_we)
  );

  // Memory behind the arbiter: 256 bytes, little-endian, wrapping addresses.
  logic [7:0] mem [256];
  always_comb begin
    mem_rd_data = '0;
    for (int i = 0; i < 32; i++) mem_rd_data[i*8 +: 8] = mem[8'(mem_rd_addr[7:0] + 8'(i))];
  end
  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_wr_sel)
        2'd1: mem[mem_wr_addr[7:0]] <= mem_wr_data[7:0];
        2'd2: for (int i = 0; i < 2; i++) mem[8'(mem_wr_addr[7:0] + 8'(i))] <= mem_wr_data[i*8 +: 8];
        2'd3: for (int i = 0; i < 4; i++) mem[8'(mem_wr_addr[7:0] + 8'(i))] <= mem_wr_data[i*8 +: 8];
        default: ;
      endcase
    end
  end

  // Reference model state.
  logic [7:0]   ref_mem [256];
  bit           last_g;        // 1 = m1 granted last
  logic [255:0] held0, held1;  // expected rdata register contents
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  typedef struct {
    bit           rd;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  wd;
    logic [1:0]   sel;
    logic [255:0] line;
    int           cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit sel_ok(input logic [1:0] s);
    return s != 2'd0;
  endfunction

  function automatic logic [255:0] ref_line(input logic [7:0] a);
    logic [255:0] l;
    logic [7:0] base;
    base = {a[7:5], 5'b0};
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = ref_mem[8'(base + 8'(i))];
    return l;
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] s);
    int nb;
    nb = (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
    for (int i = 0; i < nb; i++) ref_mem[8'(a + 8'(i))] = d[i*8 +: 8];
  endtask

  // Apply one access to the reference memory in grant order and queue its expected ack.
  task automatic model_issue(input bit port, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] s, input int ack_cyc);
    exp_t e;
    e.rd   = port || !we;
    e.we   = !port && we && sel_ok(s);
    e.addr = a;
    e.wd   = wd;
    e.sel  = s;
    e.cyc  = ack_cyc;
    e.line = '0;
    if (e.rd) e.line = ref_line(a[7:0]);
    else if (e.we) ref_write(a[7:0], wd, s);
    last_g = port;
    if (port) q1.push_back(e);
    else      q0.push_back(e);
  endtask

  // Scoreboard monitor: pops on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m0_ack) begin
        if (q0.size() == 0) chk("m0_ack_unexpected", 1'b1, 1'b0);
        else begin
          e = q0.pop_front();
          chk("m0_ack_cycle", 256'(cyc), 256'(e.cyc));
          chk("m0_mem_we", mem_we, e.we);
          if (e.rd) begin
            chk("m0_rdata", m0_rdata, e.line);
            held0 = e.line;
          end else begin
            chk("m0_rdata_hold_on_write", m0_rdata, held0);
            chk("m0_wr_addr", mem_wr_addr, e.addr);
            chk("m0_wr_data", mem_wr_data, e.wd);
            chk("m0_wr_sel", mem_wr_sel, e.sel);
          end
          chk("m1_rdata_hold", m1_rdata, held1);
        end
      end
      if (m1_ack) begin
        if (q1.size() == 0) chk("m1_ack_unexpected", 1'b1, 1'b0);
        else begin
          e = q1.pop_front();
          chk("m1_ack_cycle", 256'(cyc), 256'(e.cyc));
          chk("m1_mem_we", mem_we, 1'b0);
          chk("m1_rdata", m1_rdata, e.line);
          held1 = e.line;
          chk("m0_rdata_hold", m0_rdata, held0);
        end
      end
      if (mem_we && !m0_ack) chk("mem_we_without_m0_ack", 1'b1, 1'b0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_sel = 0; m1_addr = 0;
    held0 = '0; held1 = '0; last_g = 1'b1;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_mem_ce", mem_ce, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_m0_rdata", m0_rdata, '0);
    chk("rst_m1_rdata", m1_rdata, '0);
    chk("rst_rd_addr", mem_rd_addr, '0);
    chk("rst_wr_data", mem_wr_data, '0);
    chk("rst_wr_sel", mem_wr_sel, '0);
    rst_n = 1'b1;
  endtask

  // One access on m0, m1 or both, starting in the current cycle (called #1 after a rising edge).
  task automatic txn(input bit d0, input bit d1, input bit we, input logic [31:0] a0,
                     input logic [31:0] wd, input logic [1:0] s, input logic [31:0] a1);
    int c0, k, budget;
    bit pend0, pend1, first1, single, rd;
    logic [31:0] sa, line_a;
    c0 = cyc;
    single = d0 ^ d1;
    if (d0 && d1) begin
      first1 = !last_g;
      model_issue(first1, we, first1 ? a1 : a0, wd, s, c0 + W + 1);
      model_issue(!first1, we, first1 ? a0 : a1, wd, s, c0 + 2*W + 3);
    end else if (d0) model_issue(1'b0, we, a0, wd, s, c0 + W + 1);
    else if (d1)     model_issue(1'b1, we, a1, wd, s, c0 + W + 1);
    rd = d1 || !we;
    sa = d1 ? a1 : a0;
    line_a = {sa[31:5], 5'b0};
    m0_req = d0; m0_we = we; m0_addr = a0; m0_wdata = wd; m0_sel = s;
    m1_req = d1; m1_addr = a1;
    pend0 = d0; pend1 = d1;
    budget = 4 * (W + 2) + 8;
    while ((pend0 || pend1) && budget > 0) begin
      @(negedge clk);
      k = cyc - c0;
      if (single) begin
        chk("busy", busy, (k >= 1 && k <= W + 1));
        chk("mem_ce", mem_ce, rd && k >= 1 && k <= W);
        chk("mem_we_timing", mem_we, !rd && sel_ok(s) && k == W + 1);
        if (k >= 1 && k <= W + 1) begin
          chk("rd_addr", mem_rd_addr, rd ? line_a : sa);
          chk("wr_addr", mem_wr_addr, rd ? line_a : sa);
        end
      end
      if (m0_ack) pend0 = 0;
      if (m1_ack) pend1 = 0;
      @(posedge clk);
      #1;
      if (!pend0) m0_req = 0;
      if (!pend1) m1_req = 0;
      if (single) begin
        // Held-request input changes after the grant edge must not matter.
        m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom); m0_sel = 2'($urandom);
        m1_addr = $urandom;
      end
      budget--;
    end
    if (pend0 || pend1) chk("ack_timeout", 1'b1, 1'b0);
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    do_reset();

    // Word write then refill read of the same line.
    txn(1, 0, 1, 32'h40, 32'hDEADBEEF, 2'd3, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h0, 2'd0, 32'h40);
    chk("m1_rdata_word", m1_rdata[31:0], 32'hDEADBEEF);

    // Simultaneous requests from reset, twice.
    do_reset();
    txn(1, 1, 0, 32'h80, 32'h0, 2'd0, 32'h40);
    txn(1, 1, 1, 32'h44, 32'hCAFEF00D, 2'd2, 32'h20);

    // Unaligned refill address.
    txn(0, 1, 0, 32'h0, 32'h0, 2'd0, 32'h47);

    // Write with an unsupported size, then read back the line.
    txn(1, 0, 1, 32'h40, 32'h12345678, 2'd0, 32'h0);
    txn(1, 0, 0, 32'h40, 32'h0, 2'd0, 32'h0);

    // Reset in the middle of a write.
    m0_req = 1; m0_we = 1; m0_addr = 32'h60; m0_wdata = 32'hA5A5A5A5; m0_sel = 2'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m0_req = 0;
    held0 = '0; held1 = '0; last_g = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_m0_ack", m0_ack, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", m0_ack, 1'b0);
      chk("abort_no_we", mem_we, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(1, 0, 0, 32'h60, 32'h0, 2'd0, 32'h0);
    txn(1, 0, 1, 32'h64, 32'h01020304, 2'd1, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h0, 2'd0, 32'h64);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int pat;
      pat = $urandom_range(0, 2);
      txn(pat != 1, pat != 0, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
          2'($urandom), 32'($urandom_range(0, 255)));
    end

    repeat (2) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) chk("scoreboard_drained", 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester access controller for the byte-lane data memory. It shares one `mem_ram` between the data-side port (m0, read/write) and the instruction-refill port (m1, read-only). It grants round-robin, sequences each access through a programmable wait-state count, returns a registered 256-bit cache line on reads, and pulses the memory write enable exactly once per write. It sits between the cache/LSU request ports and `mem_ram`.

## Interface
- WAIT_CYCLES, 2: wait states per access, legal range 1..15; 4-bit counter.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  data-port request, held until m0_ack
- m0_we  in  1  1 = write, 0 = line read
- m0_addr  in  `DataAddrBus`  byte address
- m0_wdata  in  `DataBus`  write data
- m0_sel  in  `SmallMemNumlog2`  write size: `byte_sel` / `half_word_sel` / `word_sel`
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  `CacheLine`  registered read line
- m1_req  in  1  refill request, held until m1_ack
- m1_addr  in  `DataAddrBus`  byte address
- m1_ack  out  1  one-cycle completion pulse
- m1_rdata  out  `CacheLine`  registered read line
- busy  out  1  high in any state other than IDLE
- mem_ce  out  1  memory read enable
- mem_rd_addr  out  `DataAddrBus`  read address
- mem_rd_data  in  `CacheLine`  combinational line from memory
- mem_wr_addr  out  `DataAddrBus`  write address
- mem_wr_data  out  `DataBus`  write data
- mem_wr_sel  out  `SmallMemNumlog2`  write size
- mem_we  out  1  memory write enable

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: if any req is high, grant one requester and go to WAIT. On the grant edge, latch owner, we, addr, wdata and sel, and load the counter with WAIT_CYCLES-1.
- Grant from IDLE:
  - Single requester: that requester is granted.
  - Both requesting: grant the one not granted last. A `last_grant` flag is updated on every grant.
- WAIT: decrement the counter. On the edge where the counter is 0, go to DONE. For a read, load the owner's rdata register from mem_rd_data on that same edge.
- DONE: assert the owner's ack for this one cycle, then return to IDLE.
- m1 is always a read (m0_we is ignored for m1; m1 has no write fields).
- Read address: mem_rd_addr = latched addr with bits [4:0] forced to 0. The same line-aligned value drives mem_wr_addr during reads, so the memory sees one consistent address.
- Write address: mem_wr_addr = latched addr unmodified; mem_rd_addr equals it.
- mem_ce is 1 only in WAIT and only for a read.
- mem_we is 1 only in DONE, only for an m0 write with sel equal to one of the three size macros. For any other sel value, no write occurs but ack is still given.
- mem_wr_data and mem_wr_sel are driven from the latched values throughout the transaction, and held while idle.
- An rdata register changes only on its own read-capture edge. It holds its value otherwise, including across the other port's accesses.
- Requester rule: req high in the cycle after ack is treated as a new request. Address, data and we changes while req is high before ack are ignored, because latched values are used.

## Timing
- Reset values (asynchronous on rst_n low):
  - state = IDLE; busy, m0_ack, m1_ack, mem_ce, mem_we = 0.
  - m0_rdata, m1_rdata = 0; all latched address, data and sel = 0.
  - last_grant = m1, so m0 wins the first contention.
- Latency: req first sampled high in IDLE at cycle 0 → WAIT occupies cycles 1..WAIT_CYCLES → DONE, with ack, at cycle WAIT_CYCLES+1.
- Read data is valid in the ack cycle and afterwards.
- A write is committed on the clock edge that ends the DONE cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles. Two simultaneous requesters with W=2 are acked at cycles 3 and 7.
- Reset mid-transaction (rst_n low in WAIT or DONE):
  - immediate abort to IDLE, no ack, mem_we deasserted at once;
  - the pending write is lost and is not retried after reset.

## Test plan
- Reset, then check every output: all 0, busy 0, both rdata 0.
- W=2, m0 write addr 0x40, data 0xDEADBEEF, `word_sel`, req at cycle 0 → mem_we=1 and m0_ack=1 only in cycle 3, mem_wr_addr=0x40. Then m1 read 0x40 → m1_ack at cycle 3 of that access, m1_rdata[31:0]=0xDEADBEEF.
- m0 and m1 both raise req in the same cycle from reset and hold it → m0_ack cycle 3, m1_ack cycle 7. Repeat, with both raised again together → m0 granted first (last grant was m1).
- m1 read addr 0x47 → mem_rd_addr=0x40, mem_ce=1 in cycles 1-2 only.
- m0 write with sel outside the three macros → m0_ack in cycle 3, mem_we stays 0, memory contents unchanged.
- rst_n pulsed low in cycle 2 of an m0 write → no m0_ack, mem_we never 1, busy=0, state IDLE. A new request afterwards completes normally.
